entrada_bcd: RTL and testbench
==============================

ENTRADA_BCD -- requirements
Module: entrada_bcd

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive synchronized samples required to accept a button level change.
REQ-002 Parameter TAM_DADO, default 32, width of the binary result.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 req  input  1  level input request from the processor's IN instruction (halt-for-input flag).
REQ-006 button  input  1  raw, asynchronous, active-low confirm button (0 = pressed).
REQ-007 sw  input  16  four BCD digits from the switches; sw[15:12] most significant, sw[3:0] least.
REQ-008 dado  output  TAM_DADO  converted binary value, zero-extended.
REQ-009 valido  output  1  one-cycle pulse: dado/erro updated this cycle.
REQ-010 erro  output  1  set when the captured word contained a nibble > 9.
REQ-011 ocupado  output  1  high in every state except IDLE.

Function
REQ-012 button SHALL pass through a 2-flop synchronizer before any use; raw button SHALL never drive state directly.
REQ-013 Debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples of the new level; any opposite sample restarts the count.
REQ-014 FSM states: IDLE, ARMED, CONVERT, DONE, RELEASE.
REQ-015 IDLE -> ARMED when req=1 and debounced button released; with req=1 and button held, SHALL remain IDLE until debounced release.
REQ-016 ARMED -> IDLE when req=0 (abort, no valido); ARMED -> CONVERT on debounced press edge (released->pressed), capturing sw into an internal register that cycle.
REQ-017 CONVERT SHALL last exactly 4 cycles, MSD first: acc <= acc*10 + digit, acc cleared on entry; *10 implemented as (acc<<3)+(acc<<1).
REQ-018 Any captured nibble > 9 SHALL set erro and force dado to 0 at completion; conversion timing unchanged.
REQ-019 DONE lasts 1 cycle: dado and erro update, valido=1; then -> RELEASE.
REQ-020 Latency: valido asserts on the 5th rising edge after the capture edge.
REQ-021 req deassertion after capture SHALL NOT abort; conversion completes and valido still pulses.
REQ-022 RELEASE -> IDLE on debounced release; no new capture possible while button stays pressed.
REQ-023 dado and erro SHALL hold their values between valido pulses; sw changes after capture SHALL have no effect.
REQ-024 Result range 0..9999 for valid input; bits above bit 13 of dado SHALL be 0.
REQ-025 valido SHALL never be high for two consecutive cycles.

Reset
REQ-026 While reset=0 at a rising edge: state=IDLE, dado=0, erro=0, valido=0, ocupado=0, debounce counter=0, debounced level=released, synchronizer flops=1.
REQ-027 Reset asserted in any state, including mid-CONVERT, SHALL discard the capture with no valido pulse.

Verification
REQ-028 req=1, sw=16'h1234, press held 10 cycles -> capture, valido pulse 5 edges later, dado=1234, erro=0, ocupado low after release.
REQ-029 sw=16'h9999 -> dado=9999; sw=16'h0000 -> dado=0, erro=0.
REQ-030 sw=16'h12A4 -> valido pulse, dado=0, erro=1.
REQ-031 Bouncy press: button toggles every 2 cycles for 12 cycles then stable low, DEBOUNCE_CYCLES=4 -> exactly one capture, one valido.
REQ-032 req=1 with button already held -> no capture until release then fresh press; req dropped in ARMED -> IDLE, no valido; req dropped in CONVERT -> valido still pulses.
REQ-033 reset=0 on 2nd CONVERT cycle -> all outputs 0 next edge, no valido; subsequent transaction with sw=16'h0042 yields dado=42.

Source files
------------

// File: rtl/entrada_bcd.sv
// Four-digit BCD switch input for the processor's IN instruction: waits for a
// debounced button press, converts the captured BCD word to binary and pulses valido.
module entrada_bcd #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TAM_DADO        = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                button,
   input  logic [15:0]         sw,
   output logic [TAM_DADO-1:0] dado,
   output logic                valido,
   output logic                erro,
   output logic                ocupado
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      CONVERT,
      DONE,
      RELEASE
   } state_t;

   state_t                state_reg;
   logic                  sync1_reg;
   logic                  sync2_reg;
   logic                  db_level_reg;
   logic [CNT_W-1:0]      db_cnt_reg;
   logic [15:0]           cap_reg;
   logic                  bad_reg;
   logic [13:0]           acc_reg;
   logic [1:0]            step_reg;
   logic [TAM_DADO-1:0]   dado_reg;
   logic                  erro_reg;
   logic                  valido_reg;

   logic [3:0]            nib_bad;
   logic [3:0]            digit;
   logic [13:0]           acc_next;

   // Invalid-digit flags are taken from sw at capture so erro never depends on later sw.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign nib_bad[gi] = (sw[4*gi+3:4*gi] > 4'd9);
      end
   endgenerate

   assign digit    = cap_reg[15:12];
   assign acc_next = (acc_reg << 3) + (acc_reg << 1) + {10'd0, digit};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         sync1_reg    <= 1'b1;
         sync2_reg    <= 1'b1;
         db_level_reg <= 1'b1;
         db_cnt_reg   <= '0;
         cap_reg      <= '0;
         bad_reg      <= 1'b0;
         acc_reg      <= '0;
         step_reg     <= '0;
         dado_reg     <= '0;
         erro_reg     <= 1'b0;
         valido_reg   <= 1'b0;
      end else begin
         sync1_reg  <= button;
         sync2_reg  <= sync1_reg;
         valido_reg <= 1'b0;

         // Level flips only after DEBOUNCE_CYCLES consecutive opposite samples.
         if (sync2_reg == db_level_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level_reg <= sync2_reg;
            db_cnt_reg   <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (req && db_level_reg)
                  state_reg <= ARMED;
            end
            ARMED: begin
               // ARMED is only entered while released, so a pressed level here is a fresh press.
               if (!req) begin
                  state_reg <= IDLE;
               end else if (!db_level_reg) begin
                  cap_reg   <= sw;
                  bad_reg   <= |nib_bad;
                  acc_reg   <= '0;
                  step_reg  <= '0;
                  state_reg <= CONVERT;
               end
            end
            CONVERT: begin
               acc_reg  <= acc_next;
               cap_reg  <= {cap_reg[11:0], 4'h0};
               step_reg <= step_reg + 1'b1;
               if (step_reg == 2'd3)
                  state_reg <= DONE;
            end
            DONE: begin
               valido_reg <= 1'b1;
               erro_reg   <= bad_reg;
               dado_reg   <= bad_reg ? '0 : TAM_DADO'(acc_reg);
               state_reg  <= RELEASE;
            end
            RELEASE: begin
               if (db_level_reg)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign dado    = dado_reg;
   assign erro    = erro_reg;
   assign valido  = valido_reg;
   assign ocupado = (state_reg != IDLE);

endmodule

// File: tb/tb_entrada_bcd.sv
// Bench for entrada_bcd: directed and random transactions checked every cycle
// against an event-level model of the input handshake and BCD arithmetic.
module tb_entrada_bcd;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        button;
   logic [15:0] sw;
   logic [31:0] dado;
   logic        valido;
   logic        erro;
   logic        ocupado;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   entrada_bcd #(.DEBOUNCE_CYCLES(N), .TAM_DADO(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .button  (button),
      .sw      (sw),
      .dado    (dado),
      .valido  (valido),
      .erro    (erro),
      .ocupado (ocupado)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int bcd_value(input logic [15:0] w, output bit bad);
      int v = 0;
      bad = 0;
      for (int i = 3; i >= 0; i--) begin
         int d = int'((w >> (4 * i)) & 16'hF);
         if (d > 9) bad = 1;
         v = v * 10 + d;
      end
      return bad ? 0 : v;
   endfunction

   bit          model_on = 0;
   int          edge_n = 0;
   int          phase = 0;   // 0 idle, 1 waiting for press, 2 converting, 3 waiting for release
   int          due = 0;
   logic        deb = 1'b1;
   logic        win[$];
   logic        hq[$];
   logic [31:0] pend_dado;
   bit          pend_erro;
   logic [31:0] exp_dado = 0;
   logic        exp_erro = 0;
   logic        exp_valido = 0;
   logic        exp_ocupado = 0;

   always @(posedge clk) begin
      logic s;
      bit   flip;
      bit   b;
      int   v;
      edge_n++;
      if (!reset) begin
         model_on = 1;
         phase = 0;
         deb = 1'b1;
         win.delete();
         for (int i = 0; i < N; i++) win.push_back(1'b1);
         hq.delete();
         hq.push_back(1'b1);
         hq.push_back(1'b1);
         exp_dado = 0;
         exp_erro = 0;
         exp_valido = 0;
      end else if (model_on) begin
         exp_valido = 0;
         s = hq.pop_front();
         hq.push_back(button);
         case (phase)
            0: if (req && deb) phase = 1;
            1: begin
               if (!req) phase = 0;
               else if (!deb) begin
                  v = bcd_value(sw, b);
                  pend_dado = v;
                  pend_erro = b;
                  due = edge_n + 5;
                  phase = 2;
               end
            end
            2: if (edge_n == due) begin
               exp_valido = 1;
               exp_dado = pend_dado;
               exp_erro = pend_erro;
               phase = 3;
            end
            default: if (deb) phase = 0;
         endcase
         win.push_back(s);
         void'(win.pop_front());
         flip = 1;
         foreach (win[i]) if (win[i] == deb) flip = 0;
         if (flip) deb = ~deb;
      end
      exp_ocupado = (phase != 0);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_on) begin
         checks += 4;
         if (valido !== exp_valido) begin
            errors++;
            $display("FAIL valido t=%0t got %b want %b", $time, valido, exp_valido);
         end
         if (dado !== exp_dado) begin
            errors++;
            $display("FAIL dado t=%0t got %0d want %0d", $time, dado, exp_dado);
         end
         if (erro !== exp_erro) begin
            errors++;
            $display("FAIL erro t=%0t got %b want %b", $time, erro, exp_erro);
         end
         if (ocupado !== exp_ocupado) begin
            errors++;
            $display("FAIL ocupado t=%0t got %b want %b", $time, ocupado, exp_ocupado);
         end
         if (valido === 1'b1) begin
            pulses++;
            $display("txn: valido dado=%0d erro=%b t=%0t", dado, erro, $time);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic transaction(input logic [15:0] w, input int hold, input int want_dado,
                              input int want_erro, input string name);
      int p0 = pulses;
      req = 1; sw = w;
      cyc(3);
      button = 0;
      cyc(hold);
      button = 1;
      cyc(12);
      req = 0;
      cyc(3);
      expect_val({name, "_dado"}, int'(dado), want_dado);
      expect_val({name, "_erro"}, int'(erro), want_erro);
      expect_val({name, "_ocupado"}, int'(ocupado), 0);
      expect_val({name, "_pulses"}, pulses - p0, 1);
   endtask

   initial begin
      int p0;
      logic [15:0] w;
      reset = 0; req = 0; button = 1; sw = 16'h0;
      cyc(3);
      expect_val("rst_dado", int'(dado), 0);
      expect_val("rst_valido", int'(valido), 0);
      expect_val("rst_ocupado", int'(ocupado), 0);
      reset = 1;
      cyc(2);

      transaction(16'h1234, 10, 1234, 0, "t1234");
      transaction(16'h9999, 10, 9999, 0, "t9999");
      transaction(16'h0000, 10, 0, 0, "t0000");
      transaction(16'h12A4, 10, 0, 1, "t12a4");

      // bouncy press: toggles every 2 cycles, then stable low
      p0 = pulses;
      req = 1; sw = 16'h0815;
      cyc(3);
      for (int i = 0; i < 3; i++) begin
         button = 0; cyc(2);
         button = 1; cyc(2);
      end
      button = 0; cyc(10);
      button = 1; cyc(12);
      req = 0; cyc(3);
      expect_val("bounce_pulses", pulses - p0, 1);
      expect_val("bounce_dado", int'(dado), 815);

      // req raised while button already held
      p0 = pulses;
      button = 0; cyc(10);
      req = 1; sw = 16'h0321; cyc(10);
      expect_val("held_idle_ocupado", int'(ocupado), 0);
      button = 1; cyc(8);
      expect_val("held_armed_ocupado", int'(ocupado), 1);
      button = 0; cyc(10);
      button = 1; cyc(12);
      req = 0; cyc(3);
      expect_val("held_pulses", pulses - p0, 1);
      expect_val("held_dado", int'(dado), 321);

      // req dropped in ARMED
      p0 = pulses;
      req = 1; cyc(5);
      expect_val("abort_armed_ocupado", int'(ocupado), 1);
      req = 0; cyc(3);
      expect_val("abort_ocupado", int'(ocupado), 0);
      expect_val("abort_pulses", pulses - p0, 0);

      // req dropped during CONVERT
      p0 = pulses;
      req = 1; sw = 16'h0777; cyc(3);
      button = 0; cyc(8);
      req = 0; sw = 16'h1111; cyc(4);
      button = 1; cyc(12);
      expect_val("reqdrop_pulses", pulses - p0, 1);
      expect_val("reqdrop_dado", int'(dado), 777);

      // reset on the second CONVERT cycle
      p0 = pulses;
      req = 1; sw = 16'h5555; cyc(3);
      button = 0; cyc(8);
      reset = 0; cyc(1);
      expect_val("midrst_dado", int'(dado), 0);
      expect_val("midrst_ocupado", int'(ocupado), 0);
      expect_val("midrst_valido", int'(valido), 0);
      reset = 1; button = 1; req = 0; cyc(10);
      expect_val("midrst_pulses", pulses - p0, 0);
      transaction(16'h0042, 10, 42, 0, "t0042");

      // random transactions: model computes the result
      for (int t = 0; t < 10; t++) begin
         int nb;
         w = 0;
         for (int i = 0; i < 4; i++)
            w = (w << 4) | 16'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
         p0 = pulses;
         req = 1; sw = w; cyc(3);
         nb = $urandom_range(0, 6);
         for (int i = 0; i < nb; i++) begin
            button = ~button; cyc(1);
         end
         button = 0;
         cyc($urandom_range(8, 15));
         sw = 16'($urandom);
         button = 1; cyc(12);
         req = 0; cyc(3);
         expect_val("rand_pulses", pulses - p0, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
